axis_depacketizer: RTL

Receive-side counterpart of the fixed-length AXI4-Stream packetizer. Consumes a framed AXI4-Stream (tdata/tvalid/tlast) and checks every packet against a configured length. Forwards conforming words with a regenerated tlast, truncates over-long packets and counts good, short and long packets for the status bus. Sits between a DMA/network frame source and fixed-frame consumers (FIFOs, DACs, averagers).

---
 rtl/axis_depacketizer_if.sv | 24 ++
 rtl/sat_counter.sv | 18 +
 rtl/axis_depacketizer.sv | 112 +++++++++++
 3 files changed

// File: rtl/axis_depacketizer_if.sv
// AXI4-Stream bundle used around the depacketizer.
// Carries one data word with valid/ready handshake and end-of-packet flag.
interface axis_depacketizer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/sat_counter.sv
// Status counter that sticks at all-ones instead of wrapping.
// Increments by one on each cycle where inc is high.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end
endmodule

// File: rtl/axis_depacketizer.sv
// Checks incoming AXI4-Stream packets against a fixed length, forwards
// conforming words with regenerated tlast and truncates over-long packets.
module axis_depacketizer #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32,
    parameter int STS_WIDTH        = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [CNTR_WIDTH-1:0]       cfg_data,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    output logic [STS_WIDTH-1:0]        sts_good,
    output logic [STS_WIDTH-1:0]        sts_short,
    output logic [STS_WIDTH-1:0]        sts_long
);
    localparam logic RUN     = 1'b0;
    localparam logic DISCARD = 1'b1;

    logic [CNTR_WIDTH-1:0] int_data_reg;
    logic [CNTR_WIDTH-1:0] int_cntr_reg;
    logic                  int_enbl_reg;
    logic                  state;

    logic at_end;
    logic beat;
    logic in_run;
    logic pkt_good;
    logic pkt_short;
    logic pkt_long;

    // >= so a mid-packet length reduction still closes the frame
    assign at_end = int_cntr_reg >= int_data_reg;
    assign in_run = state == RUN;
    assign m_axis_tdata = s_axis_tdata;

    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        if (int_enbl_reg) begin
            if (in_run) begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = s_axis_tvalid & (s_axis_tlast | at_end);
            end else begin
                s_axis_tready = 1'b1;
            end
        end
    end

    assign beat      = s_axis_tvalid & s_axis_tready;
    assign pkt_good  = beat & in_run & s_axis_tlast & at_end;
    assign pkt_short = beat & in_run & s_axis_tlast & ~at_end;
    assign pkt_long  = beat & in_run & ~s_axis_tlast & at_end;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            int_data_reg <= '0;
            int_cntr_reg <= '0;
            int_enbl_reg <= 1'b0;
            state        <= RUN;
        end else begin
            int_data_reg <= cfg_data;
            int_enbl_reg <= 1'b1;
            if (beat) begin
                if (in_run) begin
                    if (s_axis_tlast || at_end) begin
                        int_cntr_reg <= '0;
                    end else begin
                        int_cntr_reg <= int_cntr_reg + CNTR_WIDTH'(1);
                    end
                    if (pkt_long) begin
                        state <= DISCARD;
                    end
                end else begin
                    int_cntr_reg <= '0;
                    if (s_axis_tlast) begin
                        state <= RUN;
                    end
                end
            end
        end
    end

    sat_counter #(.WIDTH(STS_WIDTH)) u_good (
        .clk  (aclk),
        .rstn (aresetn),
        .inc  (pkt_good),
        .cnt  (sts_good)
    );

    sat_counter #(.WIDTH(STS_WIDTH)) u_short (
        .clk  (aclk),
        .rstn (aresetn),
        .inc  (pkt_short),
        .cnt  (sts_short)
    );

    sat_counter #(.WIDTH(STS_WIDTH)) u_long (
        .clk  (aclk),
        .rstn (aresetn),
        .inc  (pkt_long),
        .cnt  (sts_long)
    );
endmodule
